// File: rtl/ps2_host_tx_if.sv
// Host-side command port and PS/2 line levels/pull-down enables for ps2_host_tx.
interface ps2_host_tx_if;
    logic       start;
    logic [7:0] data;
    logic       ps2_clk_s;
    logic       ps2_data_s;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       done;
    logic [1:0] err;

    modport master (
        output start, data, ps2_clk_s, ps2_data_s,
        input  ps2_clk_oe, ps2_data_oe, busy, done, err
    );

    modport slave (
        input  start, data, ps2_clk_s, ps2_data_s,
        output ps2_clk_oe, ps2_data_oe, busy, done, err
    );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, clock out one
// command byte on device clock falls, then collect the device acknowledge.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic         CLK,
    input  logic         aclr_i,
    ps2_host_tx_if.slave bus
);
    localparam int unsigned MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam int unsigned IDX_W      = 4;
    localparam int unsigned FRAME_W    = 11;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic                 nack_q, nack_d;
    logic                 clk_q;
    logic                 clk_oe_q, clk_oe_d;
    logic                 data_oe_q, data_oe_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [1:0]           err_q, err_d;

    logic                 fall_c;
    logic                 tmo_c;

    assign fall_c = clk_q & ~bus.ps2_clk_s;
    // Counter holds cycles since the last fall (or state entry); abort lands exactly TIMEOUT_CYCLES later.
    assign tmo_c  = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK or posedge aclr_i) begin
        if (aclr_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            frame_q   <= '0;
            nack_q    <= 1'b0;
            clk_q     <= 1'b1;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 2'b00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            frame_q   <= frame_d;
            nack_q    <= nack_d;
            clk_q     <= bus.ps2_clk_s;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        frame_d = frame_q;
        nack_d  = nack_q;
        done_d  = 1'b0;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                // A START coinciding with the DONE pulse is dropped.
                if (bus.start && !done_q) begin
                    frame_d = {1'b1, ~^bus.data, bus.data, 1'b0};
                    cnt_d   = '0;
                    err_d   = 2'b00;
                    state_d = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
                    state_d = REQ;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            REQ: begin
                idx_d   = '0;
                cnt_d   = CNT_W'(1);
                state_d = SEND;
            end
            SEND: begin
                // Tenth fall puts the stop bit out; ACK releases data, so it carries the stop bit.
                if (fall_c) begin
                    cnt_d = CNT_W'(1);
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(9)) begin
                        state_d = ACK;
                    end
                end else if (tmo_c) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    err_d   = 2'b10;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ACK: begin
                if (fall_c) begin
                    cnt_d   = CNT_W'(1);
                    nack_d  = bus.ps2_data_s;
                    state_d = WAIT_IDLE;
                end else if (tmo_c) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    err_d   = 2'b10;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_IDLE: begin
                if (bus.ps2_clk_s && bus.ps2_data_s) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    err_d   = {1'b0, nack_q};
                end else if (tmo_c) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    err_d   = 2'b10;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Line enables are decoded from the next state so they register alongside it.
        clk_oe_d  = (state_d == INHIBIT) || (state_d == REQ);
        data_oe_d = (state_d == REQ) || ((state_d == SEND) && !frame_d[idx_d]);
        busy_d    = (state_d != IDLE);
    end

    assign bus.ps2_clk_oe  = clk_oe_q;
    assign bus.ps2_data_oe = data_oe_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomized bench for ps2_host_tx with an open-drain PS/2 device model and
// a frame reference built from the byte's bit list and its ones count.
module tb_ps2_host_tx;
    localparam int unsigned INH = 20;
    localparam int unsigned TMO = 200;
    localparam int HI = 6;
    localparam int LO = 6;

    logic CLK      = 1'b0;
    logic aclr_i   = 1'b0;
    logic dev_clk  = 1'b1;
    logic dev_data = 1'b1;
    int   cyc       = 0;
    int   last_fall = 0;
    int   vectors     = 0;
    int   miscompares = 0;

    ps2_host_tx_if bus();

    // Wired-AND lines: either side pulling low wins.
    assign bus.ps2_clk_s  = dev_clk & ~bus.ps2_clk_oe;
    assign bus.ps2_data_s = dev_data & ~bus.ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLK   (CLK),
        .aclr_i(aclr_i),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d required < %0d", cyc, 100000);
        $fatal(1, "watchdog");
    end

    // Expected wire sequence: start, LSB-first data, odd parity, stop.
    function automatic logic [10:0] ref_frame(input logic [7:0] d);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1 + i] = d[i];
        f[9]  = (($countones(d) % 2) == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic start_xfer(input logic [7:0] d, output int t);
        @(negedge CLK);
        bus.start = 1'b1;
        bus.data  = d;
        t = cyc;
        @(negedge CLK);
        bus.start = 1'b0;
        bus.data  = 8'($urandom);
    endtask

    // Device: waits for clock release, captures the level at release and after
    // each rising edge, drives its acknowledge level before the 11th fall.
    task automatic device_run(input int n_falls, input bit ack_low, output logic [10:0] cap);
        bit rel;
        rel = 1'b0;
        cap = '0;
        for (int c = 0; c < 100; c++) begin
            @(negedge CLK);
            if (!bus.ps2_clk_oe) begin
                rel = 1'b1;
                break;
            end
        end
        if (rel) begin
            cap[0] = bus.ps2_data_s;
            for (int k = 1; k <= n_falls; k++) begin
                if (k == 11) dev_data = ~ack_low;
                repeat (HI) @(negedge CLK);
                dev_clk   = 1'b0;
                last_fall = cyc;
                repeat (LO) @(negedge CLK);
                dev_clk = 1'b1;
                if (k <= 10) cap[k] = bus.ps2_data_s;
                if (k == 11) dev_data = 1'b1;
            end
        end
    endtask

    task automatic wait_done(output bit found);
        found = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge CLK);
            if (bus.done) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [7:0]  d;
        logic [10:0] cap;
        bit          found;
        int          t;
        bus.start = 1'b0;
        bus.data  = 8'h00;
        #2 aclr_i = 1'b1;
        repeat (3) @(negedge CLK);
        vectors++;
        if ({bus.ps2_clk_oe, bus.ps2_data_oe, bus.busy, bus.done, bus.err} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_idle: got %b required %b", {bus.ps2_clk_oe, bus.ps2_data_oe, bus.busy, bus.done, bus.err}, 6'b0);
        end
        @(negedge CLK) aclr_i = 1'b0;
        repeat (2) @(negedge CLK);

        d = 8'($urandom);
        start_xfer(d, t);
        device_run(3, 1'b1, cap);
        @(negedge CLK);
        vectors++;
        if (bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_pre_busy: got %b required 1", bus.busy);
        end
        aclr_i = 1'b1;
        #1;
        vectors++;
        if ({bus.ps2_clk_oe, bus.ps2_data_oe, bus.busy, bus.done, bus.err} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_mid_send: got %b required %b", {bus.ps2_clk_oe, bus.ps2_data_oe, bus.busy, bus.done, bus.err}, 6'b0);
        end
        @(negedge CLK) aclr_i = 1'b0;
        @(negedge CLK);

        d = 8'($urandom);
        start_xfer(d, t);
        device_run(11, 1'b1, cap);
        wait_done(found);
        vectors++;
        if (cap !== ref_frame(d) || !found || bus.err !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_after_frame: got frame %b done %b err %b required frame %b done 1 err 00", cap, found, bus.err, ref_frame(d));
        end
    endtask

    task automatic test_ack_frame();
        logic [10:0] cap;
        logic [1:0]  exp;
        bit          found;
        @(negedge CLK);
        bus.start = 1'b1;
        bus.data  = 8'hED;
        for (int i = 1; i <= 22; i++) begin
            @(negedge CLK);
            if (i == 1) begin
                bus.start = 1'b0;
                bus.data  = 8'($urandom);
            end
            exp = (i <= int'(INH)) ? 2'b10 : ((i == int'(INH) + 1) ? 2'b11 : 2'b01);
            vectors++;
            if ({bus.ps2_clk_oe, bus.ps2_data_oe} !== exp || bus.busy !== 1'b1) begin
                miscompares++;
                $display("FAIL request_seq cycle t+%0d: got oe %b busy %b required oe %b busy 1", i, {bus.ps2_clk_oe, bus.ps2_data_oe}, bus.busy, exp);
            end
        end
        device_run(11, 1'b1, cap);
        wait_done(found);
        vectors++;
        if (cap !== 11'b11_1110_1101_0 || !found || bus.err !== 2'b00) begin
            miscompares++;
            $display("FAIL ed_frame: got frame %b done %b err %b required frame %b done 1 err 00", cap, found, bus.err, 11'b11_1110_1101_0);
        end
        @(negedge CLK);
        vectors++;
        if ({bus.done, bus.busy, bus.ps2_clk_oe, bus.ps2_data_oe} !== 4'b0000) begin
            miscompares++;
            $display("FAIL ed_after_done: got done/busy/oe %b required 0000", {bus.done, bus.busy, bus.ps2_clk_oe, bus.ps2_data_oe});
        end
    endtask

    task automatic test_parity();
        logic [7:0]  d;
        logic [10:0] cap;
        bit          found;
        int          t;
        for (int n = 0; n < 6; n++) begin
            d = (n == 0) ? 8'h00 : ((n == 1) ? 8'h01 : 8'($urandom));
            start_xfer(d, t);
            device_run(11, 1'b1, cap);
            wait_done(found);
            vectors++;
            if (cap !== ref_frame(d) || !found || bus.err !== 2'b00) begin
                miscompares++;
                $display("FAIL parity_frame %h: got frame %b done %b err %b required frame %b done 1 err 00", d, cap, found, bus.err, ref_frame(d));
            end
        end
    endtask

    task automatic test_nack();
        logic [7:0]  d;
        logic [10:0] cap;
        bit          found;
        int          t;
        d = 8'($urandom);
        start_xfer(d, t);
        device_run(11, 1'b0, cap);
        wait_done(found);
        vectors++;
        if (!found || bus.err !== 2'b01 || {bus.ps2_clk_oe, bus.ps2_data_oe} !== 2'b00 || cap !== ref_frame(d)) begin
            miscompares++;
            $display("FAIL nack: got done %b err %b oe %b frame %b required done 1 err 01 oe 00 frame %b", found, bus.err, {bus.ps2_clk_oe, bus.ps2_data_oe}, cap, ref_frame(d));
        end
    endtask

    task automatic test_timeout();
        logic [7:0]  d;
        logic [10:0] cap;
        logic [10:0] fr;
        int          t;
        d  = 8'($urandom) & 8'hF7;
        fr = ref_frame(d);
        start_xfer(d, t);
        device_run(4, 1'b1, cap);
        vectors++;
        if (cap[4:0] !== fr[4:0]) begin
            miscompares++;
            $display("FAIL timeout_partial: got %b required %b", cap[4:0], fr[4:0]);
        end
        for (int c = 0; c < 400 && cyc < last_fall + int'(TMO) - 1; c++) @(negedge CLK);
        // Bit DATA[3] is zero, so the line is still pulled one cycle before the abort.
        vectors++;
        if (bus.done !== 1'b0 || bus.ps2_data_oe !== 1'b1 || bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_early at fall+%0d: got done %b data_oe %b busy %b required 0 1 1", cyc - last_fall, bus.done, bus.ps2_data_oe, bus.busy);
        end
        @(negedge CLK);
        vectors++;
        if (bus.done !== 1'b1 || bus.err !== 2'b10 || bus.busy !== 1'b0 || {bus.ps2_clk_oe, bus.ps2_data_oe} !== 2'b00) begin
            miscompares++;
            $display("FAIL timeout_abort at fall+%0d: got done %b err %b busy %b oe %b required 1 10 0 00", cyc - last_fall, bus.done, bus.err, bus.busy, {bus.ps2_clk_oe, bus.ps2_data_oe});
        end
        @(negedge CLK);
        vectors++;
        if (bus.done !== 1'b0 || bus.err !== 2'b10) begin
            miscompares++;
            $display("FAIL timeout_hold: got done %b err %b required 0 10", bus.done, bus.err);
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] cap;
        bit          found;
        int          t;
        int          n_done;
        n_done = 0;
        start_xfer(8'hFF, t);
        fork
            device_run(11, 1'b1, cap);
            begin
                for (int c = 0; c < 600; c++) begin
                    @(negedge CLK);
                    if (bus.done) n_done++;
                    if (!bus.busy) break;
                    bus.start = ((c % 7) == 3);
                    bus.data  = 8'h55;
                end
                bus.start = 1'b0;
            end
        join
        vectors++;
        if (cap !== ref_frame(8'hFF) || n_done != 1 || bus.err !== 2'b00) begin
            miscompares++;
            $display("FAIL busy_ignore: got frame %b dones %0d err %b required frame %b dones 1 err 00", cap, n_done, bus.err, ref_frame(8'hFF));
        end
        bus.start = 1'b1;
        bus.data  = 8'h55;
        @(negedge CLK);
        vectors++;
        if (bus.busy !== 1'b0 || bus.ps2_clk_oe !== 1'b0) begin
            miscompares++;
            $display("FAIL start_on_done: got busy %b clk_oe %b required 0 0", bus.busy, bus.ps2_clk_oe);
        end
        @(negedge CLK);
        bus.start = 1'b0;
        vectors++;
        if (bus.busy !== 1'b1 || bus.ps2_clk_oe !== 1'b1) begin
            miscompares++;
            $display("FAIL start_after_done: got busy %b clk_oe %b required 1 1", bus.busy, bus.ps2_clk_oe);
        end
        device_run(11, 1'b1, cap);
        wait_done(found);
        vectors++;
        if (cap !== ref_frame(8'h55) || !found || bus.err !== 2'b00) begin
            miscompares++;
            $display("FAIL next_frame: got frame %b done %b err %b required frame %b done 1 err 00", cap, found, bus.err, ref_frame(8'h55));
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.data  = 8'h00;
        test_reset();
        test_ack_frame();
        test_parity();
        test_nack();
        test_timeout();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
